// File: rtl/edge_span_pkg.sv
// Shared types and defaults for the edge span measurement stage and its divider.
package edge_span_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    CHECK = 3'd2,
    DIV   = 3'd3,
    OUT   = 3'd4
  } span_state_t;

  localparam int unsigned N_EDGES_DEF = 30;
  localparam int unsigned X_W_DEF     = 11;
  localparam int unsigned DIST_W_DEF  = 16;

  // Wide enough that a cast to any practical distance width stays all ones.
  localparam logic [63:0] DIST_NONE = {64{1'b1}};

endpackage

// File: rtl/seq_divider.sv
// Fixed-latency restoring divider: one quotient bit per cycle, the first bit
// computed on the start cycle, done pulses once the last bit is registered.
module seq_divider #(
  parameter int unsigned DIST_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIST_W-1:0] dividend,
  input  logic [DIST_W-1:0] divisor,
  output logic              done,
  output logic [DIST_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIST_W + 1);

  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DIST_W:0]   rem_r;
  logic [DIST_W-1:0] dvd_r;
  logic [DIST_W-1:0] dvs_r;
  logic [DIST_W-1:0] quo_r;

  logic [DIST_W:0]   rem_in_s;
  logic              bit_in_s;
  logic [DIST_W-1:0] dvs_s;
  logic [DIST_W:0]   shifted_s;
  logic [DIST_W:0]   rem_next_s;
  logic              q_bit_s;

  // One restoring step, fed from the inputs on start and from the registers otherwise.
  always_comb begin
    rem_in_s   = '0;
    bit_in_s   = 1'b0;
    dvs_s      = '0;
    rem_next_s = '0;
    q_bit_s    = 1'b0;
    if (start) begin
      rem_in_s = '0;
      bit_in_s = dividend[DIST_W-1];
      dvs_s    = divisor;
    end else begin
      rem_in_s = rem_r;
      bit_in_s = dvd_r[DIST_W-1];
      dvs_s    = dvs_r;
    end
    shifted_s = {rem_in_s[DIST_W-1:0], bit_in_s};
    if (shifted_s >= {1'b0, dvs_s}) begin
      rem_next_s = shifted_s - {1'b0, dvs_s};
      q_bit_s    = 1'b1;
    end else begin
      rem_next_s = shifted_s;
      q_bit_s    = 1'b0;
    end
  end

  // Iteration state and quotient accumulation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= '0;
      rem_r  <= '0;
      dvd_r  <= '0;
      dvs_r  <= '0;
      quo_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        busy_r <= 1'b1;
        cnt_r  <= CNT_W'(DIST_W - 1);
        rem_r  <= rem_next_s;
        dvd_r  <= {dividend[DIST_W-2:0], 1'b0};
        dvs_r  <= divisor;
        quo_r  <= {{(DIST_W-1){1'b0}}, q_bit_s};
      end else if (busy_r) begin
        rem_r <= rem_next_s;
        dvd_r <= {dvd_r[DIST_W-2:0], 1'b0};
        quo_r <= {quo_r[DIST_W-2:0], q_bit_s};
        cnt_r <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign done     = done_r;
  assign quotient = quo_r;

endmodule

// File: rtl/edge_span_measure.sv
// Per-frame widest-gap finder over the edge list, with distance estimated as
// DIST_K / width and presented over a valid/ready handshake.
module edge_span_measure
  import edge_span_pkg::*;
#(
  parameter int unsigned     N_EDGES   = N_EDGES_DEF,
  parameter int unsigned     X_W       = X_W_DEF,
  parameter int unsigned     DIST_W    = DIST_W_DEF,
  parameter logic [DIST_W-1:0] DIST_K  = 16'd46080,
  parameter int unsigned     MIN_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_done,
  input  logic [N_EDGES-1:0][X_W-1:0]    measured_list,
  input  logic                           result_ready,
  output logic                           result_valid,
  output logic [5:0]                     edge_count,
  output logic [X_W-1:0]                 obj_width,
  output logic [X_W-1:0]                 obj_centre,
  output logic [DIST_W-1:0]              distance,
  output logic                           no_object,
  output logic                           overrun
);

  localparam int unsigned IDX_W    = $clog2(N_EDGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EDGES - 1);

  span_state_t                 state_r;
  logic [N_EDGES-1:0][X_W-1:0] snap_r;
  logic [IDX_W-1:0]            idx_r;
  logic                        stop_r;
  logic [5:0]                  count_r;
  logic [X_W-1:0]              prev_r;
  logic [X_W-1:0]              best_gap_r;
  logic [X_W-1:0]              best_left_r;
  logic [X_W-1:0]              best_right_r;
  logic [X_W-1:0]              width_hold_r;
  logic [X_W-1:0]              centre_hold_r;
  logic                        pend_r;

  logic                        valid_r;
  logic [5:0]                  edge_count_r;
  logic [X_W-1:0]              obj_width_r;
  logic [X_W-1:0]              obj_centre_r;
  logic [DIST_W-1:0]           distance_r;
  logic                        no_object_r;
  logic                        overrun_r;

  logic [X_W-1:0]              cur_s;
  logic [X_W-1:0]              gap_s;
  logic [X_W:0]                sum_s;
  logic                        no_obj_s;
  logic                        div_start_s;
  logic                        div_done_s;
  logic [DIST_W-1:0]           quotient_s;
  logic                        drop_s;
  logic                        out_entry_s;
  logic [X_W-1:0]              res_width_s;
  logic [X_W-1:0]              res_centre_s;
  logic [DIST_W-1:0]           res_dist_s;
  logic                        res_no_obj_s;

  seq_divider #(
    .DIST_W (DIST_W)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start_s),
    .dividend (DIST_K),
    .divisor  (DIST_W'(width_div_s())),
    .done     (div_done_s),
    .quotient (quotient_s)
  );

  function automatic logic [X_W-1:0] width_div_s();
    return best_gap_r;
  endfunction

  // Scan datapath, object decision and the result fields presented on OUT entry.
  always_comb begin
    cur_s        = snap_r[0];
    gap_s        = cur_s - prev_r;
    sum_s        = {1'b0, best_left_r} + {1'b0, best_right_r};
    no_obj_s     = (count_r < 6'd2) || (best_gap_r < X_W'(MIN_WIDTH));
    drop_s       = frame_done && (state_r != IDLE);
    div_start_s  = 1'b0;
    out_entry_s  = 1'b0;
    res_width_s  = '0;
    res_centre_s = '0;
    res_dist_s   = DIST_W'(DIST_NONE);
    res_no_obj_s = 1'b1;
    case (state_r)
      CHECK: begin
        if (no_obj_s) begin
          out_entry_s = 1'b1;
        end else begin
          div_start_s = 1'b1;
        end
      end
      DIV: begin
        if (div_done_s) begin
          out_entry_s  = 1'b1;
          res_width_s  = width_hold_r;
          res_centre_s = centre_hold_r;
          res_dist_s   = quotient_s;
          res_no_obj_s = 1'b0;
        end else begin
          out_entry_s = 1'b0;
        end
      end
      default: begin
        out_entry_s = 1'b0;
      end
    endcase
  end

  // Frame FSM with registered result fields.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      snap_r        <= '0;
      idx_r         <= '0;
      stop_r        <= 1'b0;
      count_r       <= '0;
      prev_r        <= '0;
      best_gap_r    <= '0;
      best_left_r   <= '0;
      best_right_r  <= '0;
      width_hold_r  <= '0;
      centre_hold_r <= '0;
      pend_r        <= 1'b0;
      valid_r       <= 1'b0;
      edge_count_r  <= '0;
      obj_width_r   <= '0;
      obj_centre_r  <= '0;
      distance_r    <= '0;
      no_object_r   <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_done) begin
            snap_r       <= measured_list;
            idx_r        <= '0;
            stop_r       <= 1'b0;
            count_r      <= '0;
            prev_r       <= '0;
            best_gap_r   <= '0;
            best_left_r  <= '0;
            best_right_r <= '0;
            state_r      <= SCAN;
          end
        end
        SCAN: begin
          // The first zero entry terminates the list; later entries are ignored.
          if (!stop_r) begin
            if (cur_s == '0) begin
              stop_r <= 1'b1;
            end else begin
              count_r <= count_r + 6'd1;
              if ((idx_r != '0) && (gap_s > best_gap_r)) begin
                best_gap_r   <= gap_s;
                best_left_r  <= prev_r;
                best_right_r <= cur_s;
              end
            end
          end
          prev_r <= cur_s;
          snap_r <= {X_W'(0), snap_r[N_EDGES-1:1]};
          idx_r  <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            state_r <= CHECK;
          end
        end
        CHECK: begin
          width_hold_r  <= best_gap_r;
          centre_hold_r <= sum_s[X_W:1];
          if (!no_obj_s) begin
            state_r <= DIV;
          end
        end
        DIV: begin
        end
        OUT: begin
          if (result_ready) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (out_entry_s) begin
        state_r      <= OUT;
        valid_r      <= 1'b1;
        edge_count_r <= count_r;
        obj_width_r  <= res_width_s;
        obj_centre_r <= res_centre_s;
        distance_r   <= res_dist_s;
        no_object_r  <= res_no_obj_s;
        overrun_r    <= pend_r | drop_s;
        pend_r       <= 1'b0;
      end else if (drop_s) begin
        pend_r <= 1'b1;
      end
    end
  end

  assign result_valid = valid_r;
  assign edge_count   = edge_count_r;
  assign obj_width    = obj_width_r;
  assign obj_centre   = obj_centre_r;
  assign distance     = distance_r;
  assign no_object    = no_object_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_edge_span_measure.sv
// Directed bench for edge_span_measure: latency, gap selection, no-object cases,
// backpressure with overrun, and reset during division.
module tb_edge_span_measure;
  import edge_span_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 frame_done = 1'b0;
  logic                 result_ready = 1'b0;
  logic [29:0][10:0]    measured_list = '0;
  logic                 result_valid;
  logic [5:0]           edge_count;
  logic [10:0]          obj_width;
  logic [10:0]          obj_centre;
  logic [15:0]          distance;
  logic                 no_object;
  logic                 overrun;

  int tests_run = 0;
  int tests_failed = 0;

  edge_span_measure dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_done    (frame_done),
    .measured_list (measured_list),
    .result_ready  (result_ready),
    .result_valid  (result_valid),
    .edge_count    (edge_count),
    .obj_width     (obj_width),
    .obj_centre    (obj_centre),
    .distance      (distance),
    .no_object     (no_object),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic run_frame(input logic [29:0][10:0] l, output int lat);
    @(negedge clk);
    measured_list = l;
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({result_valid, edge_count, obj_width, obj_centre, distance, no_object, overrun} !== 47'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%0b count=%0d width=%0d centre=%0d dist=%0d noobj=%0b ovr=%0b, expected all 0",
               result_valid, edge_count, obj_width, obj_centre, distance, no_object, overrun);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_object();
    logic [29:0][10:0] l;
    int lat;
    l = '0;
    l[0] = 11'd100; l[1] = 11'd200; l[2] = 11'd260;
    run_frame(l, lat);
    tests_run++;
    if (lat !== 47) begin
      tests_failed++;
      $display("FAIL object_latency: got %0d expected 47", lat);
    end
    tests_run++;
    if ({edge_count, obj_width, obj_centre, distance, no_object, overrun} !== {6'd3, 11'd100, 11'd150, 16'd460, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL object_fields: count=%0d width=%0d centre=%0d dist=%0d noobj=%0b ovr=%0b, expected 3 100 150 460 0 0",
               edge_count, obj_width, obj_centre, distance, no_object, overrun);
    end
    accept();
    tests_run++;
    if (result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL object_accept: valid=%0b expected 0", result_valid);
    end
  endtask

  task automatic test_single();
    logic [29:0][10:0] l;
    int lat;
    l = '0;
    l[0] = 11'd300;
    run_frame(l, lat);
    tests_run++;
    if (lat !== 31) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d expected 31", lat);
    end
    tests_run++;
    if ({edge_count, obj_width, obj_centre, distance, no_object} !== {6'd1, 11'd0, 11'd0, 16'hFFFF, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_fields: count=%0d width=%0d centre=%0d dist=%0d noobj=%0b, expected 1 0 0 65535 1",
               edge_count, obj_width, obj_centre, distance, no_object);
    end
    accept();
  endtask

  task automatic test_small_gap();
    logic [29:0][10:0] l;
    int lat;
    l = '0;
    l[0] = 11'd100; l[1] = 11'd102;
    run_frame(l, lat);
    tests_run++;
    if (lat !== 31) begin
      tests_failed++;
      $display("FAIL small_gap_latency: got %0d expected 31", lat);
    end
    tests_run++;
    if ({edge_count, obj_width, distance, no_object} !== {6'd2, 11'd0, 16'hFFFF, 1'b1}) begin
      tests_failed++;
      $display("FAIL small_gap_fields: count=%0d width=%0d dist=%0d noobj=%0b, expected 2 0 65535 1",
               edge_count, obj_width, distance, no_object);
    end
    accept();
  endtask

  task automatic test_full_list();
    logic [29:0][10:0] l;
    int lat;
    for (int k = 0; k < 30; k++) l[k] = 11'(31 + 19 * k);
    run_frame(l, lat);
    tests_run++;
    if (lat !== 47) begin
      tests_failed++;
      $display("FAIL full_latency: got %0d expected 47", lat);
    end
    tests_run++;
    if ({edge_count, obj_width, obj_centre, distance, no_object} !== {6'd30, 11'd19, 11'd40, 16'd2425, 1'b0}) begin
      tests_failed++;
      $display("FAIL full_fields: count=%0d width=%0d centre=%0d dist=%0d noobj=%0b, expected 30 19 40 2425 0",
               edge_count, obj_width, obj_centre, distance, no_object);
    end
    accept();
  endtask

  task automatic test_backpressure_overrun();
    logic [29:0][10:0] l;
    int lat;
    l = '0;
    l[0] = 11'd100; l[1] = 11'd200; l[2] = 11'd260;
    run_frame(l, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      frame_done = (i == 3);
      @(posedge clk);
      #1;
      tests_run++;
      if ({result_valid, edge_count, obj_width, obj_centre, distance, no_object, overrun} !==
          {1'b1, 6'd3, 11'd100, 11'd150, 16'd460, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_cycle_%0d: valid=%0b count=%0d width=%0d centre=%0d dist=%0d ovr=%0b, expected 1 3 100 150 460 0",
                 i, result_valid, edge_count, obj_width, obj_centre, distance, overrun);
      end
    end
    frame_done = 1'b0;
    accept();
    tests_run++;
    if ({result_valid, overrun} !== 2'b00) begin
      tests_failed++;
      $display("FAIL hold_accept: valid=%0b ovr=%0b expected 0 0", result_valid, overrun);
    end
    l = '0;
    l[0] = 11'd50; l[1] = 11'd150;
    run_frame(l, lat);
    tests_run++;
    if ({edge_count, obj_width, obj_centre, distance, overrun} !== {6'd2, 11'd100, 11'd100, 16'd460, 1'b1} || lat !== 47) begin
      tests_failed++;
      $display("FAIL overrun_shown: lat=%0d count=%0d width=%0d centre=%0d dist=%0d ovr=%0b, expected 47 2 100 100 460 1",
               lat, edge_count, obj_width, obj_centre, distance, overrun);
    end
    accept();
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: ovr=%0b expected 0", overrun);
    end
    run_frame(l, lat);
    tests_run++;
    if (overrun !== 1'b0 || lat !== 47) begin
      tests_failed++;
      $display("FAIL overrun_next: lat=%0d ovr=%0b expected 47 0", lat, overrun);
    end
    accept();
  endtask

  task automatic test_reset_mid_div();
    logic [29:0][10:0] l;
    int lat;
    int seen;
    for (int k = 0; k < 30; k++) l[k] = 11'(31 + 19 * k);
    @(negedge clk);
    measured_list = l;
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    repeat (36) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_valid, edge_count, obj_width, obj_centre, distance, no_object, overrun} !== 47'd0) begin
      tests_failed++;
      $display("FAIL div_reset_outputs: valid=%0b count=%0d width=%0d centre=%0d dist=%0d noobj=%0b ovr=%0b, expected all 0",
               result_valid, edge_count, obj_width, obj_centre, distance, no_object, overrun);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (result_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL div_reset_discard: valid cycles=%0d expected 0", seen);
    end
    run_frame(l, lat);
    tests_run++;
    if ({edge_count, obj_width, obj_centre, distance, no_object} !== {6'd30, 11'd19, 11'd40, 16'd2425, 1'b0} || lat !== 47) begin
      tests_failed++;
      $display("FAIL div_reset_rerun: lat=%0d count=%0d width=%0d centre=%0d dist=%0d noobj=%0b, expected 47 30 19 40 2425 0",
               lat, edge_count, obj_width, obj_centre, distance, no_object);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_object();
    test_single();
    test_small_gap();
    test_full_list();
    test_backpressure_overrun();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
